teclado_pin: RTL and testbench
==============================

Name: teclado_pin

Overview:
Keypad front-end that produces the PIN-digit interface consumed by the PIN-entry receiver: `digito` and a one-cycle `digito_stb`, plus clear and enter pulses.
- Scans a 4x3 matrix keypad column by column and debounces across full sweeps.
- Emits exactly one event per physical key press; no auto-repeat.
- Sits between the keypad pins and the cashier control FSM.

Parameters:
- SCAN_CICLOS, 4, clock cycles each column is driven before its rows are sampled (>=2).
- DEBOUNCE, 3, consecutive identical sweeps required to accept a press, and consecutive empty sweeps required to accept a release (>=1, <=15).

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- habilitar  input  1  high = key events may be emitted; low = scanning continues but events are dropped.
- filas  input  4  row sense lines, active-high; bit r high = key at row r in the driven column is closed.
- columnas  output  3  one-hot column drive, active-high.
- digito  output  4  value of the last accepted digit key (0-9).
- digito_stb  output  1  one-cycle pulse; `digito` is valid in that cycle.
- borrar  output  1  one-cycle pulse for '*'.
- enter  output  1  one-cycle pulse for '#'.
- tecla_activa  output  1  high while an accepted key is considered held.

Behaviour:
- Key map, listed as row: col0 col1 col2.
  - r0: 1 2 3
  - r1: 4 5 6
  - r2: 7 8 9
  - r3: * 0 #
- Reset (async, reset=0):
  - columnas=3'b001; digito=0; digito_stb=borrar=enter=tecla_activa=0.
  - Scan counter, column index and debounce counters cleared; FSM set to REPOSO.
  - Takes effect immediately, mid-sweep or mid-debounce. The first sweep starts at column 0 on the first clock after release.
- Scan:
  - Each column is driven for SCAN_CICLOS cycles, sequence 0→1→2→0.
  - `filas` is sampled in the last cycle of each column dwell.
  - One sweep = 3*SCAN_CICLOS cycles (12 at default).
  - At the column-2 sample the sweep result is formed from the three samples: NINGUNA (no bit set), UNICA (exactly one bit over all 12) with its key code, or MULTIPLE (>=2 bits).
- Debounce FSM, evaluated once per sweep result (cuenta is 4 bits):
  - REPOSO:
    - UNICA → VALIDANDO, cuenta=1, tecla=code.
    - NINGUNA or MULTIPLE → stay.
    - If DEBOUNCE=1, UNICA instead goes straight to PRESIONADA and emits.
  - VALIDANDO:
    - UNICA with the same code → cuenta+1; when cuenta reaches DEBOUNCE → emit the event, go to PRESIONADA.
    - Different code, NINGUNA or MULTIPLE → REPOSO, no event.
  - PRESIONADA:
    - tecla_activa=1.
    - NINGUNA → LIBERANDO, cuenta=1 (if DEBOUNCE=1 → REPOSO).
    - Anything else → stay.
  - LIBERANDO:
    - tecla_activa=1.
    - NINGUNA → cuenta+1; at DEBOUNCE → REPOSO, tecla_activa=0.
    - UNICA or MULTIPLE → PRESIONADA.
    - No new event is ever emitted from release/re-press bounce.
- Emission:
  - Registered; the pulse appears in the cycle after the sweep-end sample that completes validation.
  - Digit key: digito updated to its value and digito_stb=1 for exactly one cycle.
  - '*': borrar=1 for one cycle. '#': enter=1 for one cycle. For both, digito is unchanged.
  - At most one of digito_stb/borrar/enter is high in any cycle.
- habilitar:
  - Sampled in the emission cycle. If low, the pulse and the digito update are suppressed, but the FSM still enters PRESIONADA (the press is consumed).
  - Raising habilitar while a key is held does not produce an event.
- Latency: a key closed before a sweep starts and held stable is emitted DEBOUNCE sweeps later. At default, the pulse occurs 36 cycles after the start of the first sweep that sees it.
- digito holds its value indefinitely between strobes.

Test Plan:
1. habilitar=1; assert filas[1] only while columnas=3'b010 ('5') for 6 sweeps, then release → exactly one digito_stb with digito=5, ~36 cycles after sweep start. tecla_activa rises with the strobe and falls 3 empty sweeps after release.
2. Press/release '1','2','3','4' in turn, each held 4 sweeps with 4 empty sweeps between → four strobes carrying 1,2,3,4 in order, no extra pulses.
3. Bounce: '7' present 2 sweeps, absent 1, present 2, then absent → no digito_stb. Hold '7' during release with 1 empty sweep between held sweeps → still only one strobe.
4. Press '*' then '#', each held 4 sweeps → one borrar pulse, then one enter pulse; digito_stb never high; digito keeps its prior value.
5. '2' and '8' closed together for 5 sweeps → no events; tecla_activa stays 0.
6. habilitar=0 while pressing '9' → no pulses, digito unchanged. Then drive reset=0 mid-VALIDANDO of '3' → outputs cleared immediately, columnas=3'b001, and no event after reset release until a fresh 3-sweep press.

Source files
------------

// File: rtl/teclado_pin_if.sv
// Keypad front-end signal bundle.
// Carries the pins between the keypad matrix and the consumer (PIN receiver):
//   habilitar    - event enable from the consumer
//   filas[3:0]   - row sense lines from the keypad, active-high
//   columnas[2:0]- one-hot column drive to the keypad
//   digito[3:0]  - last accepted digit
//   digito_stb   - one-cycle digit strobe
//   borrar       - one-cycle '*' pulse
//   enter        - one-cycle '#' pulse
//   tecla_activa - an accepted key is held
// slave: the keypad front-end; master: the environment around it.
interface teclado_pin_if;
    logic       habilitar;
    logic [3:0] filas;
    logic [2:0] columnas;
    logic [3:0] digito;
    logic       digito_stb;
    logic       borrar;
    logic       enter;
    logic       tecla_activa;

    modport slave (
        input  habilitar, filas,
        output columnas, digito, digito_stb, borrar, enter, tecla_activa
    );

    modport master (
        output habilitar, filas,
        input  columnas, digito, digito_stb, borrar, enter, tecla_activa
    );
endinterface

// File: rtl/teclado_pin.sv
// 4x3 matrix keypad scanner with sweep-level debouncing.
// Drives one column at a time, samples the rows at the end of each column
// dwell and classifies every full sweep as no key / one key / several keys.
// A key is accepted after DEBOUNCE identical single-key sweeps and released
// after DEBOUNCE empty sweeps; exactly one event is emitted per press.
// Ports:
//   clk   - system clock, posedge
//   reset - asynchronous, active-low
//   kp    - teclado_pin_if.slave (habilitar, filas in; columnas, digito,
//           digito_stb, borrar, enter, tecla_activa out)
module teclado_pin #(
    parameter int SCAN_CICLOS = 4,
    parameter int DEBOUNCE    = 3
) (
    input  logic          clk,
    input  logic          reset,
    teclado_pin_if.slave  kp
);

    localparam int CW = (SCAN_CICLOS > 2) ? $clog2(SCAN_CICLOS) : 1;

    typedef enum logic [1:0] {REPOSO, VALIDANDO, PRESIONADA, LIBERANDO} estado_t;

    logic [CW-1:0] scan_q;
    logic [2:0]    col_q;
    logic [1:0]    hits_q;     // keys seen so far in this sweep, saturating at 2
    logic [3:0]    code_q;     // code of the first key seen this sweep
    estado_t       estado_q;
    logic [3:0]    cuenta_q;
    logic [3:0]    tecla_q;
    logic [3:0]    digito_q;
    logic          stb_q, borrar_q, enter_q, activa_q;

    logic          muestra, fin_barrido;
    logic [2:0]    n_bits, suma;
    logic [1:0]    fila_idx, col_idx, hits_d;
    logic [3:0]    code_d;
    logic          res_ninguna, res_unica, emite;
    logic [4:0]    cuenta_mas1;

    always_comb begin
        muestra     = (scan_q == CW'(SCAN_CICLOS - 1));
        fin_barrido = muestra & col_q[2];
        n_bits      = 3'(kp.filas[0]) + 3'(kp.filas[1]) + 3'(kp.filas[2]) + 3'(kp.filas[3]);
        fila_idx    = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            if (kp.filas[r]) fila_idx = 2'(r);
        end
        col_idx     = col_q[2] ? 2'd2 : (col_q[1] ? 2'd1 : 2'd0);
        suma        = 3'(hits_q) + n_bits;
        hits_d      = (suma >= 3'd2) ? 2'd2 : suma[1:0];
        // Key code = row*3 + col; only meaningful when the sweep holds one key.
        code_d      = (hits_q == 2'd0) ? (4'(fila_idx) * 4'd3 + 4'(col_idx)) : code_q;
        res_ninguna = (suma == 3'd0);
        res_unica   = (suma == 3'd1);
        cuenta_mas1 = {1'b0, cuenta_q} + 5'd1;
        emite       = fin_barrido && res_unica &&
                      (((estado_q == REPOSO) && (DEBOUNCE == 1)) ||
                       ((estado_q == VALIDANDO) && (code_d == tecla_q) &&
                        (cuenta_mas1 == 5'(DEBOUNCE))));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_q <= '0;
            col_q  <= 3'b001;
            hits_q <= '0;
            code_q <= '0;
        end else if (muestra) begin
            scan_q <= '0;
            col_q  <= {col_q[1:0], col_q[2]};
            hits_q <= col_q[2] ? 2'd0 : hits_d;
            code_q <= code_d;
        end else begin
            scan_q <= scan_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q <= REPOSO;
            cuenta_q <= '0;
            tecla_q  <= '0;
            digito_q <= '0;
            stb_q    <= 1'b0;
            borrar_q <= 1'b0;
            enter_q  <= 1'b0;
            activa_q <= 1'b0;
        end else begin
            stb_q    <= 1'b0;
            borrar_q <= 1'b0;
            enter_q  <= 1'b0;
            if (fin_barrido) begin
                case (estado_q)
                    REPOSO: begin
                        if (res_unica) begin
                            tecla_q  <= code_d;
                            cuenta_q <= 4'd1;
                            if (emite) begin
                                estado_q <= PRESIONADA;
                                activa_q <= 1'b1;
                            end else begin
                                estado_q <= VALIDANDO;
                            end
                        end
                    end
                    VALIDANDO: begin
                        if (emite) begin
                            estado_q <= PRESIONADA;
                            activa_q <= 1'b1;
                        end else if (res_unica && (code_d == tecla_q)) begin
                            cuenta_q <= cuenta_mas1[3:0];
                        end else begin
                            estado_q <= REPOSO;
                        end
                    end
                    PRESIONADA: begin
                        if (res_ninguna) begin
                            cuenta_q <= 4'd1;
                            if (DEBOUNCE == 1) begin
                                estado_q <= REPOSO;
                                activa_q <= 1'b0;
                            end else begin
                                estado_q <= LIBERANDO;
                            end
                        end
                    end
                    LIBERANDO: begin
                        if (!res_ninguna) begin
                            estado_q <= PRESIONADA;
                        end else if (cuenta_mas1 == 5'(DEBOUNCE)) begin
                            estado_q <= REPOSO;
                            activa_q <= 1'b0;
                        end else begin
                            cuenta_q <= cuenta_mas1[3:0];
                        end
                    end
                    default: estado_q <= REPOSO;
                endcase
            end
            // The press is consumed even when habilitar is low; only the pulse is dropped.
            if (emite && kp.habilitar) begin
                if (code_d == 4'd9) begin
                    borrar_q <= 1'b1;
                end else if (code_d == 4'd11) begin
                    enter_q <= 1'b1;
                end else begin
                    stb_q    <= 1'b1;
                    digito_q <= (code_d == 4'd10) ? 4'd0 : code_d + 4'd1;
                end
            end
        end
    end

    assign kp.columnas     = col_q;
    assign kp.digito       = digito_q;
    assign kp.digito_stb   = stb_q;
    assign kp.borrar       = borrar_q;
    assign kp.enter        = enter_q;
    assign kp.tecla_activa = activa_q;

endmodule

// File: tb/tb_teclado_pin.sv
// Testbench for teclado_pin: keypad matrix model, sweep-level reference model,
// event scoreboard with a decoupled pulse monitor.
module tb_teclado_pin;

    localparam int SC  = 4;
    localparam int D   = 3;
    localparam int SWP = 3 * SC;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] pressed;   // bit r*3+c = key at row r, column c closed
    int          cyc = 0;
    int          passed = 0;
    int          total = 0;

    typedef struct {int kind; int val; int cyc;} ev_t;  // kind 0 digit, 1 '*', 2 '#'
    ev_t q[$];

    // reference model state
    bit m_held;
    int m_key, m_streak, m_empty, m_dig, sweep_idx;

    teclado_pin_if ifc ();

    teclado_pin #(.SCAN_CICLOS(SC), .DEBOUNCE(D)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (ifc.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= reset ? cyc + 1 : 0;

    always_comb begin
        ifc.filas = '0;
        for (int r = 0; r < 4; r++) ifc.filas[r] = |(ifc.columnas & pressed[r*3 +: 3]);
    end

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a pulse.
    always @(negedge clk) begin
        if (reset && (ifc.digito_stb || ifc.borrar || ifc.enter)) begin
            ev_t e;
            chk("pulse_onehot", int'(ifc.digito_stb) + int'(ifc.borrar) + int'(ifc.enter), 1);
            if (q.size() == 0) begin
                total++;
                $display("FAIL unexpected_pulse: got stb=%0b borrar=%0b enter=%0b digito=%0d expected none (cycle %0d)",
                         ifc.digito_stb, ifc.borrar, ifc.enter, ifc.digito, cyc);
            end else begin
                e = q.pop_front();
                chk("pulse_kind", ifc.borrar ? 1 : (ifc.enter ? 2 : 0), e.kind);
                chk("pulse_cycle", cyc, e.cyc);
                chk("pulse_digito", int'(ifc.digito), e.val);
            end
        end
    end

    function automatic int key_val(input int k);
        return (k == 10) ? 0 : k + 1;
    endfunction

    // One full sweep with a fixed set of closed keys; the model is advanced
    // from the spec rules and any expected event is queued before it can occur.
    task automatic sweep(input logic [11:0] m);
        int n;
        int key;
        ev_t e;
        pressed = m;
        sweep_idx++;
        n = $countones(m);
        key = -1;
        for (int i = 0; i < 12; i++) if (m[i]) key = i;
        if (!m_held) begin
            if (n == 1) begin
                if (m_streak == 0) begin
                    m_streak = 1;
                    m_key = key;
                end else if (key == m_key) begin
                    m_streak++;
                end else begin
                    m_streak = 0;
                end
                if (m_streak == D) begin
                    m_held = 1;
                    m_empty = 0;
                    if (ifc.habilitar) begin
                        e.kind = (key == 9) ? 1 : ((key == 11) ? 2 : 0);
                        if (e.kind == 0) m_dig = key_val(key);
                        e.val = m_dig;
                        e.cyc = SWP * sweep_idx;
                        q.push_back(e);
                    end
                end
            end else begin
                m_streak = 0;
            end
        end else begin
            if (n == 0) begin
                m_empty++;
                if (m_empty == D) begin
                    m_held = 0;
                    m_streak = 0;
                end
            end else begin
                m_empty = 0;
            end
        end
        repeat (SWP) @(negedge clk);
        chk("tecla_activa", int'(ifc.tecla_activa), int'(m_held));
        chk("digito_hold", int'(ifc.digito), m_dig);
    endtask

    task automatic sweeps(input logic [11:0] m, input int n);
        for (int i = 0; i < n; i++) sweep(m);
    endtask

    task automatic model_reset();
        m_held = 0; m_key = -1; m_streak = 0; m_empty = 0; m_dig = 0; sweep_idx = 0;
        q.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_columnas"}, int'(ifc.columnas), 1);
        chk({tag, "_digito"}, int'(ifc.digito), 0);
        chk({tag, "_pulses"}, int'({ifc.digito_stb, ifc.borrar, ifc.enter}), 0);
        chk({tag, "_activa"}, int'(ifc.tecla_activa), 0);
    endtask

    function automatic logic [11:0] bitk(input int k);
        logic [11:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    initial begin
        reset = 1'b0;
        pressed = '0;
        ifc.habilitar = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b1;

        // '5' held 6 sweeps, then released
        sweeps(bitk(4), 6);
        sweeps('0, 4);

        // '1'..'4' in turn
        for (int k = 0; k < 4; k++) begin
            sweeps(bitk(k), 4);
            sweeps('0, 4);
        end

        // '7' with bounce before acceptance: no event
        sweeps(bitk(6), 2);
        sweeps('0, 1);
        sweeps(bitk(6), 2);
        sweeps('0, 4);
        // '7' accepted, release bounce: single event
        sweeps(bitk(6), 3);
        sweeps('0, 1);
        sweeps(bitk(6), 2);
        sweeps('0, 4);

        // '*' then '#'
        sweeps(bitk(9), 4);
        sweeps('0, 4);
        sweeps(bitk(11), 4);
        sweeps('0, 4);

        // '2' and '8' together
        sweeps(bitk(1) | bitk(7), 5);
        sweeps('0, 4);

        // habilitar low while pressing '9', raised while still held
        ifc.habilitar = 1'b0;
        sweeps(bitk(8), 4);
        ifc.habilitar = 1'b1;
        sweeps(bitk(8), 2);
        sweeps('0, 4);

        // reset in the middle of validating '3'
        sweeps(bitk(2), 2);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        sweeps(bitk(2), 2);
        sweeps('0, 2);
        sweeps(bitk(2), 3);
        sweeps('0, 4);

        // randomized key activity
        for (int it = 0; it < 40; it++) begin
            int r;
            int k1;
            int k2;
            logic [11:0] m;
            r = $urandom_range(0, 9);
            k1 = $urandom_range(0, 11);
            k2 = (k1 + 1 + $urandom_range(0, 10)) % 12;
            if (r < 2) m = '0;
            else if (r < 8) m = bitk(k1);
            else m = bitk(k1) | bitk(k2);
            ifc.habilitar = ($urandom_range(0, 5) != 0);
            sweeps(m, $urandom_range(1, 5));
        end
        ifc.habilitar = 1'b1;
        sweeps('0, 4);

        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
